// File: rtl/gain_corr_pkg.sv
// rtl/gain_corr_pkg.sv - shared widths, unity coefficient and saturating shift for gain correction
package gain_corr_pkg;

    localparam int AXIS_TUSER_WIDTH = 1;
    localparam int AXIS_TID_WIDTH   = 4;
    localparam int AXIS_TDEST_WIDTH = 4;

    function automatic int coef_width(input int int_width, input int fract_width);
        return int_width + fract_width;
    endfunction

    // Unity gain; a format without integer bits cannot hold 1.0.
    function automatic int fixed_one(input int int_width, input int fract_width);
        return (int_width > 0) ? (1 << fract_width) : 0;
    endfunction

    // Payload rounded up to whole bytes, as used by every video stream block.
    function automatic int tdata_width(input int payload_bits);
        return ((payload_bits + 7) / 8) * 8;
    endfunction

    // Shift right, then clamp to the largest out_width-bit unsigned value.
    function automatic logic [31:0] sat_shift_right(input logic [63:0] value, input int shift,
                                                    input int out_width);
        logic [63:0] shifted;
        logic [63:0] max_val;
        shifted = value >> shift;
        max_val = (64'd1 << out_width) - 64'd1;
        return (shifted > max_val) ? 32'(max_val) : 32'(shifted);
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = gain_corr_pkg::AXIS_TUSER_WIDTH,
    parameter int TID_WIDTH   = gain_corr_pkg::AXIS_TID_WIDTH,
    parameter int TDEST_WIDTH = gain_corr_pkg::AXIS_TDEST_WIDTH
);
    logic [TDATA_WIDTH-1:0]   tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;

    modport master (output tdata, tvalid, tlast, tuser, tkeep, tstrb, tid, tdest, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, tkeep, tstrb, tid, tdest, output tready);
endinterface

// File: rtl/gain_corr_channel.sv
// rtl/gain_corr_channel.sv - one colour component: slice, multiply, round (GAIN_CORR_ROUNDING_EN) and saturate
module gain_corr_channel
    import gain_corr_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int COEF_WIDTH  = 14,
    parameter int FRACT_WIDTH = 10,
    parameter int TDATA_WIDTH = 32,
    parameter int CH_INDEX    = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_mult_i,
    input  logic                   load_out_i,
    input  logic [TDATA_WIDTH-1:0] tdata_i,
    input  logic [COEF_WIDTH-1:0]  coef_i,
    output logic [PX_WIDTH-1:0]    px_o
);
    localparam int PROD_WIDTH = PX_WIDTH + COEF_WIDTH;

    logic [PX_WIDTH-1:0]   px;
    logic [PROD_WIDTH-1:0] prod;

    assign px = PX_WIDTH'(tdata_i >> (CH_INDEX * PX_WIDTH));

`ifdef GAIN_CORR_ROUNDING_EN
    // One extra bit so adding the half-LSB can never wrap.
    localparam logic [PROD_WIDTH:0] ROUND_HALF = (PROD_WIDTH + 1)'(1) << (FRACT_WIDTH - 1);
    logic [PROD_WIDTH:0] prod_adj;
    assign prod_adj = {1'b0, prod} + ROUND_HALF;
`else
    logic [PROD_WIDTH-1:0] prod_adj;
    assign prod_adj = prod;
`endif

    // Stage 1: full-precision product of pixel and coefficient.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod <= '0;
        end else if (load_mult_i) begin
            prod <= PROD_WIDTH'(px) * PROD_WIDTH'(coef_i);
        end
    end

    // Stage 2: drop fractional bits and clamp to full scale.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            px_o <= '0;
        end else if (load_out_i) begin
            px_o <= PX_WIDTH'(sat_shift_right(64'(prod_adj), FRACT_WIDTH, PX_WIDTH));
        end
    end

endmodule

// File: rtl/multi_channel_gain_corrector.sv
// rtl/multi_channel_gain_corrector.sv - per-channel video gain with frame-aligned coefficient commit (GAIN_CORR_ROUNDING_EN selects rounding)
module multi_channel_gain_corrector
    import gain_corr_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int CHANNELS    = 3,
    parameter int FRACT_WIDTH = 10,
    parameter int INT_WIDTH   = 4,
    localparam int COEF_WIDTH = coef_width(INT_WIDTH, FRACT_WIDTH),
    localparam int CH_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi4_stream_if.slave          video_i,
    axi4_stream_if.master         video_o,
    input  logic                  coef_we_i,
    input  logic [CH_WIDTH-1:0]   coef_ch_i,
    input  logic [COEF_WIDTH-1:0] coef_data_i,
    input  logic                  coef_commit_i,
    output logic [COEF_WIDTH-1:0] coef_rd_o,
    output logic                  coef_pending_o
);
    localparam int TDATA_WIDTH = tdata_width(PX_WIDTH * CHANNELS);
    localparam int KEEP_WIDTH  = TDATA_WIDTH / 8;
    localparam logic [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(fixed_one(INT_WIDTH, FRACT_WIDTH));

    logic s1_valid, out_valid, s1_ready, s2_ready, s2_load;
    logic accept, frame_commit, commit, ch_valid;

    logic [COEF_WIDTH-1:0] shadow     [CHANNELS];
    logic [COEF_WIDTH-1:0] active     [CHANNELS];
    logic [COEF_WIDTH-1:0] stage_coef [CHANNELS];
    logic [PX_WIDTH-1:0]   px_out     [CHANNELS];
    logic [TDATA_WIDTH-1:0] out_data;

    logic                        s1_last, out_last;
    logic [AXIS_TUSER_WIDTH-1:0] s1_user, out_user;
    logic [KEEP_WIDTH-1:0]       s1_keep, out_keep, s1_strb, out_strb;
    logic [AXIS_TID_WIDTH-1:0]   s1_id, out_id;
    logic [AXIS_TDEST_WIDTH-1:0] s1_dest, out_dest;

    assign s2_ready       = !out_valid || video_o.tready;
    assign s1_ready       = !s1_valid || s2_ready;
    assign s2_load        = s2_ready && s1_valid;
    assign video_i.tready = s1_ready;
    assign accept         = video_i.tvalid && s1_ready;
    assign frame_commit   = accept && video_i.tuser[0] && coef_pending_o;
    assign commit         = frame_commit || coef_commit_i;
    assign ch_valid       = int'(coef_ch_i) < CHANNELS;

    // A start-of-frame commit must already apply to the beat that triggers it.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            stage_coef[k] = frame_commit ? shadow[k] : active[k];
        end
    end

    // Shadow/active coefficient banks and the pending flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= COEF_ONE;
                active[k] <= COEF_ONE;
            end
            coef_pending_o <= 1'b0;
        end else begin
            if (commit) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (coef_we_i && ch_valid) begin
                shadow[coef_ch_i] <= coef_data_i;
                coef_pending_o    <= 1'b1;
            end else if (commit) begin
                coef_pending_o <= 1'b0;
            end
        end
    end

    // Registered readback of the active coefficient, tracking a commit in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coef_rd_o <= COEF_ONE;
        end else if (!ch_valid) begin
            coef_rd_o <= '0;
        end else if (commit) begin
            coef_rd_o <= shadow[coef_ch_i];
        end else begin
            coef_rd_o <= active[coef_ch_i];
        end
    end

    // Two-slot valid pipeline carrying the sideband alongside the channel datapaths.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_last   <= 1'b0;
            s1_user   <= '0;
            s1_keep   <= '0;
            s1_strb   <= '0;
            s1_id     <= '0;
            s1_dest   <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
            out_keep  <= '0;
            out_strb  <= '0;
            out_id    <= '0;
            out_dest  <= '0;
        end else begin
            if (s1_ready) begin
                s1_valid <= video_i.tvalid;
            end
            if (accept) begin
                s1_last <= video_i.tlast;
                s1_user <= video_i.tuser;
                s1_keep <= video_i.tkeep;
                s1_strb <= video_i.tstrb;
                s1_id   <= video_i.tid;
                s1_dest <= video_i.tdest;
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s2_load) begin
                out_last <= s1_last;
                out_user <= s1_user;
                out_keep <= s1_keep;
                out_strb <= s1_strb;
                out_id   <= s1_id;
                out_dest <= s1_dest;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        gain_corr_channel #(
            .PX_WIDTH    (PX_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH),
            .FRACT_WIDTH (FRACT_WIDTH),
            .TDATA_WIDTH (TDATA_WIDTH),
            .CH_INDEX    (k)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_mult_i (accept),
            .load_out_i  (s2_load),
            .tdata_i     (video_i.tdata),
            .coef_i      (stage_coef[k]),
            .px_o        (px_out[k])
        );
    end

    // Pack channel results; padding above the last channel stays zero.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            out_data[k*PX_WIDTH +: PX_WIDTH] = px_out[k];
        end
    end

    assign video_o.tvalid = out_valid;
    assign video_o.tdata  = out_data;
    assign video_o.tlast  = out_last;
    assign video_o.tuser  = out_user;
    assign video_o.tkeep  = out_keep;
    assign video_o.tstrb  = out_strb;
    assign video_o.tid    = out_id;
    assign video_o.tdest  = out_dest;

endmodule

// File: tb/tb_multi_channel_gain_corrector.sv
// tb/tb_multi_channel_gain_corrector.sv - scoreboard bench for multi_channel_gain_corrector
module tb_multi_channel_gain_corrector;

    typedef struct {
        logic [31:0] data;
        logic [17:0] side;
        time         t;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic        coef_we;
    logic [1:0]  coef_ch;
    logic [13:0] coef_data;
    logic        coef_commit;
    logic [13:0] coef_rd;
    logic        coef_pending;

    axi4_stream_if #(.TDATA_WIDTH(32)) vin ();
    axi4_stream_if #(.TDATA_WIDTH(32)) vout ();

    multi_channel_gain_corrector #(
        .PX_WIDTH    (10),
        .CHANNELS    (3),
        .FRACT_WIDTH (10),
        .INT_WIDTH   (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .video_i        (vin),
        .video_o        (vout),
        .coef_we_i      (coef_we),
        .coef_ch_i      (coef_ch),
        .coef_data_i    (coef_data),
        .coef_commit_i  (coef_commit),
        .coef_rd_o      (coef_rd),
        .coef_pending_o (coef_pending)
    );

    int   checks = 0;
    int   errors = 0;
    int   sink_mode = 0;
    bit   lat_chk = 1;
    exp_t sb[$];
    int   m_active[3];
    int   m_shadow[3];
    bit   m_pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [9:0] model_px(input int px, input int coef);
        longint r;
        r = longint'(px) * longint'(coef);
`ifdef GAIN_CORR_ROUNDING_EN
        r = r + 512;
`endif
        r = r >>> 10;
        return (r > 1023) ? 10'd1023 : 10'(r);
    endfunction

    always @(posedge clk) begin
        #1;
        case (sink_mode)
            0:       vout.tready = 1'b1;
            1:       vout.tready = ($urandom_range(0, 99) < 30);
            default: vout.tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_i) begin
            if (!vin.tready) check("stall_depth", sb.size(), 2);
            if (vout.tvalid && vout.tready) begin
                check("out_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("tdata", vout.tdata, e.data);
                    check("sideband", {vout.tlast, vout.tuser, vout.tkeep, vout.tstrb,
                                       vout.tid, vout.tdest}, e.side);
                    if (lat_chk) check("latency", $time - e.t, 15);
                end
            end
        end
    end

    task automatic send_beat(input int p0, input int p1, input int p2, input bit user, input bit last);
        exp_t       e;
        int         n;
        logic [3:0] keep, strb, id, dest;
        keep = 4'($urandom);
        strb = 4'($urandom);
        id   = 4'($urandom);
        dest = 4'($urandom);
        vin.tdata  = {2'b00, 10'(p2), 10'(p1), 10'(p0)};
        vin.tuser  = user;
        vin.tlast  = last;
        vin.tkeep  = keep;
        vin.tstrb  = strb;
        vin.tid    = id;
        vin.tdest  = dest;
        vin.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!vin.tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!vin.tready) begin
            check("accept_timeout", vin.tready, 1);
            vin.tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        if (user && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        e.data = {2'b00, model_px(p2, m_active[2]), model_px(p1, m_active[1]), model_px(p0, m_active[0])};
        e.side = {last, user, keep, strb, id, dest};
        e.t    = $time;
        sb.push_back(e);
        #1 vin.tvalid = 1'b0;
    endtask

    task automatic write_coef(input int ch, input int val);
        coef_we   = 1'b1;
        coef_ch   = 2'(ch);
        coef_data = 14'(val);
        @(posedge clk);
        if (ch < 3) begin
            m_shadow[ch] = val;
            m_pending    = 1'b1;
        end
        #1 coef_we = 1'b0;
    endtask

    task automatic commit_coefs();
        coef_commit = 1'b1;
        @(posedge clk);
        m_active  = m_shadow;
        m_pending = 1'b0;
        #1 coef_commit = 1'b0;
    endtask

    task automatic write_and_commit(input int ch, input int val);
        coef_we     = 1'b1;
        coef_commit = 1'b1;
        coef_ch     = 2'(ch);
        coef_data   = 14'(val);
        @(posedge clk);
        m_active     = m_shadow;
        m_shadow[ch] = val;
        m_pending    = 1'b1;
        #1;
        coef_we     = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic read_check(input int ch);
        int want;
        coef_ch = 2'(ch);
        @(posedge clk);
        #1;
        want = 0;
        if (ch < 3) want = m_active[ch];
        check($sformatf("coef_rd_ch%0d", ch), coef_rd, want);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_i       = 1'b1;
        vin.tvalid  = 1'b0;
        vin.tdata   = '0;
        vin.tuser   = '0;
        vin.tlast   = 1'b0;
        vin.tkeep   = '0;
        vin.tstrb   = '0;
        vin.tid     = '0;
        vin.tdest   = '0;
        coef_we     = 1'b0;
        coef_ch     = 2'd0;
        coef_data   = '0;
        coef_commit = 1'b0;
        m_active    = '{1024, 1024, 1024};
        m_shadow    = '{1024, 1024, 1024};
        m_pending   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        check("rst_tvalid", vout.tvalid, 0);
        check("rst_tdata", vout.tdata, 0);
        check("rst_side", {vout.tlast, vout.tuser, vout.tkeep, vout.tstrb, vout.tid, vout.tdest}, 0);
        check("rst_coef_rd", coef_rd, 1024);
        check("rst_pending", coef_pending, 0);
        check("rst_tready", vin.tready, 1);

        // Unity gain after reset
        send_beat(1023, 512, 1, 1'b1, 1'b0);
        send_beat(0, 1023, 700, 1'b0, 1'b1);
        wait_drain(100);

        // Gain 1.5, saturation and rounding on channel 0
        write_coef(0, 1536);
        commit_coefs();
        read_check(0);
        send_beat(600, 10, 20, 1'b1, 1'b0);
        send_beat(800, 10, 20, 1'b0, 1'b0);
        send_beat(3, 10, 20, 1'b0, 1'b1);
        wait_drain(100);

        // Frame-aligned commit of ch2 = 2.0
        send_beat(100, 200, 300, 1'b1, 1'b0);
        write_coef(2, 2048);
        check("pend_after_write", coef_pending, 1);
        send_beat(100, 200, 300, 1'b0, 1'b0);
        send_beat(5, 6, 7, 1'b0, 1'b1);
        check("pend_midframe", coef_pending, 1);
        send_beat(100, 200, 300, 1'b1, 1'b0);
        check("pend_after_sof", coef_pending, 0);
        send_beat(11, 12, 511, 1'b0, 1'b1);
        wait_drain(100);
        read_check(2);

        // Out-of-range channel
        write_coef(3, 999);
        check("pend_bad_ch", coef_pending, 0);
        read_check(3);

        // Write and commit in the same cycle
        write_and_commit(1, 1500);
        check("pend_we_commit", coef_pending, 1);
        read_check(1);
        commit_coefs();
        read_check(1);

        // Random backpressure over a 64x4 frame
        lat_chk   = 1'b0;
        sink_mode = 1;
        for (int line = 0; line < 4; line++) begin
            for (int x = 0; x < 64; x++) begin
                send_beat($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                          (line == 0 && x == 0), (x == 63));
            end
        end
        wait_drain(5000);
        sink_mode = 0;
        repeat (2) @(posedge clk);
        #1 lat_chk = 1'b1;

        // Reset mid-frame with gain 2.0 active
        write_coef(0, 2048);
        write_coef(1, 2048);
        write_coef(2, 2048);
        commit_coefs();
        sink_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_beat(100, 200, 300, 1'b1, 1'b0);
        send_beat(101, 201, 301, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        check("rst_mid_tvalid", vout.tvalid, 0);
        sb.delete();
        m_active  = '{1024, 1024, 1024};
        m_shadow  = '{1024, 1024, 1024};
        m_pending = 1'b0;
        sink_mode = 0;
        @(posedge clk);
        #1 rst_i = 1'b0;
        check("rst_mid_pending", coef_pending, 0);
        read_check(0);
        read_check(2);
        for (int x = 0; x < 8; x++) begin
            send_beat(x * 100, 1023 - x, x + 1, (x == 0), (x == 7));
        end
        wait_drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
